sat_round_trunc: RTL and testbench

//  Pipelined fixed-point narrowing stage: takes a 2N-bit signed product (2F fraction bits) and returns
//  an N-bit signed word (F fraction bits). Supports selectable rounding, saturation with a flag, and

---
 rtl/sat_round_pkg.sv | 33 +++
 rtl/sat_event_counter.sv | 30 +++
 rtl/sat_round_trunc.sv | 132 +++++++++++++
 tb/tb_sat_round_trunc.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_round_pkg.sv
// Shared constants and clamp helpers for the
// fixed-point narrowing stage.
package sat_round_pkg;

  localparam int MAXW = 64;

  localparam logic [1:0] ROUND_TRUNC     = 2'd0;
  localparam logic [1:0] ROUND_HALF_UP   = 2'd1;
  localparam logic [1:0] ROUND_HALF_EVEN = 2'd2;

  function automatic logic [MAXW-1:0] sat_pos(
    input int n
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAXW-1:0] sat_neg(
    input int n
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i == n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with synchronous
// clear; clear wins over a same-cycle event.
module sat_event_counter
  import sat_round_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/sat_round_trunc.sv
// Two-stage round/saturate narrowing stage:
// 2N-bit product with 2F frac -> N-bit word with F frac.
module sat_round_trunc
  import sat_round_pkg::*;
#(
  parameter int N     = 25,
  parameter int F     = 14,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_data,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  input  logic             sat_count_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam int SW = 2 * N + 1;
  localparam int TW = N - F + 2;

  localparam logic [SW-1:0] ONE  = SW'(1);
  localparam logic [SW-1:0] HALF = ONE << (F - 1);

  localparam logic [MAXW-1:0] POS64 = sat_pos(N);
  localparam logic [MAXW-1:0] NEG64 = sat_neg(N);
  localparam logic [N-1:0]    SAT_P = POS64[N-1:0];
  localparam logic [N-1:0]    SAT_N = NEG64[N-1:0];

  logic          w_en;
  logic          w_accept;
  logic [SW-1:0] w_ext;
  logic [SW-1:0] w_inc;
  logic [SW-1:0] w_sum;

  logic          r_s1_valid;
  logic [SW-1:0] r_s1_sum;

  logic [TW-1:0] w_top;
  logic          w_in_range;
  logic [N-1:0]  w_kept;
  logic [N-1:0]  w_res;
  logic          w_sat;

  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic          r_out_sat;

  logic          w_cnt_inc;

  // Whole pipe advances together; a stalled
  // output freezes S1 as well.
  assign w_en     = !r_out_valid | out_ready;
  assign in_ready = w_en & !reset;
  assign w_accept = in_valid & in_ready;

  assign w_ext = {in_data[2*N-1], in_data};

  always_comb begin
    w_inc = '0;
    unique case (1'b1)
      (round_mode == ROUND_HALF_UP):
        w_inc = HALF;
      (round_mode == ROUND_HALF_EVEN):
        w_inc = HALF - ONE + SW'(in_data[F]);
      default:
        w_inc = '0;
    endcase
  end

  // One guard bit so a rounding carry out of
  // the top saturates instead of wrapping.
  assign w_sum = w_ext + w_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_sum <= w_sum;
    end
  end

  assign w_top      = r_s1_sum[SW-1:N+F-1];
  assign w_in_range = (&w_top) | ~(|w_top);
  assign w_kept     = r_s1_sum[N+F-1:F];

  always_comb begin
    w_res = w_kept;
    w_sat = 1'b0;
    if (!w_in_range) begin
      w_sat = 1'b1;
      w_res = r_s1_sum[SW-1] ? SAT_N : SAT_P;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_res;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  assign w_cnt_inc = r_out_valid & out_ready & r_out_sat;

  sat_event_counter #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_cnt_inc),
    .clr   (sat_count_clr),
    .count (sat_count)
  );

endmodule

// File: tb/tb_sat_round_trunc.sv
// Bench for sat_round_trunc: directed corner
// vectors plus random traffic vs. arithmetic model.
module tb_sat_round_trunc;

  localparam int N     = 25;
  localparam int F     = 14;
  localparam int CNT_W = 4;

  typedef struct {
    logic [N-1:0] d;
    logic         s;
    int           cyc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_data;
  logic [1:0]       round_mode;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_sat;
  logic             sat_count_clr;
  logic [CNT_W-1:0] sat_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_in   = 0;
  int n_out  = 0;
  int mcnt   = 0;
  bit free_run = 0;
  bit stalled  = 0;
  logic [N-1:0] held_d;
  logic         held_s;
  logic [N-1:0] last_d;
  logic         last_s;
  exp_t q[$];

  sat_round_trunc #(
    .N     (N),
    .F     (F),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .round_mode    (round_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
    .sat_count_clr (sat_count_clr),
    .sat_count     (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, want);
    end
  endtask

  // Reference: exact rational rounding of v/2^14,
  // then clamp to the signed 25-bit range.
  function automatic exp_t model(logic [2*N-1:0] d,
                                 logic [1:0] m);
    exp_t   e;
    longint v;
    longint qq;
    longint r;
    v  = {{(64-2*N){d[2*N-1]}}, d};
    qq = v >>> F;
    r  = v - qq * 16384;
    if (m == 2'd1) begin
      qq = (v + 8192) >>> F;
    end else if (m == 2'd2) begin
      if (r > 8192) qq++;
      else if (r == 8192 && (qq % 2 != 0)) qq++;
    end
    e.cyc = 0;
    if (qq > 64'sd16777215) begin
      e.d = 25'h0FFFFFF;
      e.s = 1'b1;
    end else if (qq < -64'sd16777216) begin
      e.d = 25'h1000000;
      e.s = 1'b1;
    end else begin
      e.d = qq[N-1:0];
      e.s = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      mcnt    = 0;
      stalled = 0;
    end else begin
      check("sat_count", 64'(sat_count), 64'(mcnt));
      check("in_ready", 64'(in_ready),
            64'(!out_valid || out_ready));
      if (stalled && out_valid) begin
        check("hold_data", 64'(out_data), 64'(held_d));
        check("hold_sat", 64'(out_sat), 64'(held_s));
      end
      if (sat_count_clr) mcnt = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("out_unexpected", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_sat", 64'(out_sat), 64'(e.s));
          if (free_run)
            check("latency", 64'(cyc - e.cyc), 64'd2);
          if (e.s && !sat_count_clr && mcnt < 15) mcnt++;
          n_out++;
          last_d = out_data;
          last_s = out_sat;
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_s  = out_sat;
      if (in_valid && in_ready) begin
        e     = model(in_data, round_mode);
        e.cyc = cyc;
        q.push_back(e);
        n_in++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(longint v, logic [1:0] m);
    bit ok;
    ok         = 0;
    in_valid   = 1'b1;
    in_data    = v[2*N-1:0];
    round_mode = m;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      tick();
      if (q.size() == 0 && !out_valid) break;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic vec(string tag, longint v,
                     logic [1:0] m,
                     logic [N-1:0] ed, logic es);
    free_run  = 1;
    out_ready = 1'b1;
    drive(v, m);
    in_valid = 1'b0;
    wait_drain();
    check({tag, "_d"}, 64'(last_d), 64'(ed));
    check({tag, "_s"}, 64'(last_s), 64'(es));
  endtask

  function automatic longint gen();
    longint v;
    longint qq;
    int     k;
    k = $urandom_range(0, 3);
    if (k == 0) begin
      v = {$urandom, $urandom};
      v = (v <<< (64 - 2*N)) >>> (64 - 2*N);
    end else if (k == 1) begin
      qq = longint'($urandom_range(0, 1 << 26)) - (1 << 25);
      v  = qq * 16384 + longint'($urandom_range(0, 16383));
    end else if (k == 2) begin
      qq = longint'($urandom_range(0, 1 << 26)) - (1 << 25);
      v  = qq * 16384 + 8192;
    end else begin
      qq = ($urandom_range(0, 1) != 0) ? (1 << 24) : -(1 << 24);
      qq = qq + longint'($urandom_range(0, 4)) - 2;
      v  = qq * 16384 + longint'($urandom_range(8190, 8194));
    end
    return v;
  endfunction

  initial begin
    exp_t   ea;
    int     in0;
    int     out0;
    longint vs;
    vs            = longint'(1) << 40;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    round_mode    = 2'd0;
    out_ready     = 1'b1;
    sat_count_clr = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    tick();

    vec("tie_t",   64'sh0A000, 2'd0, 25'd2, 1'b0);
    vec("tie_hu",  64'sh0A000, 2'd1, 25'd3, 1'b0);
    vec("tie_he",  64'sh0A000, 2'd2, 25'd2, 1'b0);
    vec("tie_he3", 64'sh0E000, 2'd2, 25'd4, 1'b0);
    vec("tie_m3",  64'sh0E000, 2'd3, 25'd3, 1'b0);
    vec("ntie_t",  -64'sh0A000, 2'd0, 25'h1FFFFFD, 1'b0);
    vec("ntie_hu", -64'sh0A000, 2'd1, 25'h1FFFFFE, 1'b0);
    vec("ntie_he", -64'sh0A000, 2'd2, 25'h1FFFFFE, 1'b0);
    vec("pos_sat", longint'(1) << 38, 2'd0, 25'h0FFFFFF, 1'b1);
    vec("neg_min", -(longint'(1) << 38), 2'd0, 25'h1000000, 1'b0);
    vec("neg_sat", -(longint'(1) << 38) - 1, 2'd0,
        25'h1000000, 1'b1);
    vec("one_5", 64'sh1800_0000, 2'd0, 25'h0006000, 1'b0);
    vec("rov_hu", 64'sh3FFFFFC000 + 64'sh2000, 2'd1,
        25'h0FFFFFF, 1'b1);
    vec("rov_t", 64'sh3FFFFFC000 + 64'sh2000, 2'd0,
        25'h0FFFFFF, 1'b0);

    free_run  = 0;
    in0       = n_in;
    out0      = n_out;
    out_ready = 1'b0;
    ea        = model(50'h0A000, 2'd1);
    drive(64'sh0A000, 2'd1);
    drive(64'sh1800_0000, 2'd0);
    in_data = 50'h0E000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(ea.d));
    end
    check("bp_accepted", 64'(n_in - in0), 64'd2);
    tick();
    out_ready = 1'b1;
    drive(64'sh0E000, 2'd2);
    drive(-64'sh0A000, 2'd0);
    drive(longint'(1) << 38, 2'd0);
    in_valid = 1'b0;
    wait_drain();
    check("bp_in5", 64'(n_in - in0), 64'd5);
    check("bp_out5", 64'(n_out - out0), 64'd5);

    for (int i = 0; i < 400; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = gen();
      round_mode    = 2'($urandom_range(0, 3));
      out_ready     = ($urandom_range(0, 3) != 0);
      sat_count_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid      = 1'b0;
    sat_count_clr = 1'b0;
    out_ready     = 1'b1;
    wait_drain();

    free_run = 1;
    for (int i = 0; i < 100; i++) begin
      in_valid   = 1'b1;
      in_data    = gen();
      round_mode = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    wait_drain();

    sat_count_clr = 1'b1;
    tick();
    sat_count_clr = 1'b0;
    check("cnt_cleared", 64'(sat_count), 64'd0);
    for (int i = 0; i < 17; i++) drive(vs, 2'd0);
    in_valid = 1'b0;
    wait_drain();
    check("cnt_sat15", 64'(sat_count), 64'd15);

    drive(vs, 2'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      tick();
    end
    check("clr_pre_valid", 64'(out_valid), 64'd1);
    sat_count_clr = 1'b1;
    tick();
    sat_count_clr = 1'b0;
    check("cnt_clr_win", 64'(sat_count), 64'd0);

    free_run  = 0;
    out_ready = 1'b0;
    drive(vs, 2'd0);
    in_valid = 1'b0;
    repeat (5) tick();
    check("stall_valid", 64'(out_valid), 64'd1);
    check("cnt_stall", 64'(sat_count), 64'd0);
    out_ready = 1'b1;
    tick();
    check("cnt_after", 64'(sat_count), 64'd1);
    wait_drain();

    out_ready = 1'b0;
    drive(vs, 2'd0);
    drive(-vs, 2'd0);
    in_valid = 1'b0;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_cnt", 64'(sat_count), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_cnt", 64'(sat_count), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("no_stale", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout CHECKS %0d ERRORS %0d",
             checks, errors);
    $fatal(1, "timeout");
  end

endmodule
